// File: rtl/tdd_pkg.sv
// tdd_pkg: shared constants and FSM state type for the TDD frame scheduler
package tdd_pkg;
   localparam int CNT_W_DEF = 24;
   localparam int MIN_LEN   = 2;
   typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/tdd_window_cmp.sv
// tdd_window_cmp: start-inclusive/end-exclusive window test with frame-wrap support
module tdd_window_cmp
   import tdd_pkg::*;
#(
   parameter int W = CNT_W_DEF
) (
   input  logic [W-1:0] s,
   input  logic [W-1:0] e,
   input  logic [W-1:0] c,
   input  logic [W-1:0] len,
   output logic         active
);
   // s > e wraps across the frame boundary; s == e is an empty window
   always_comb active = c < len && (s < e ? c >= s && c < e : s > e && (c >= s || c < e));
endmodule

// File: rtl/tdd_frame_sched.sv
// tdd_frame_sched: TDD frame counter driving rx/tx enables; define TDD_SYNC_EN for external resync
module tdd_frame_sched
   import tdd_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [CNT_W-1:0] frame_len,
   input  logic [CNT_W-1:0] frame_adj,
   input  logic             adj_req,
   input  logic [CNT_W-1:0] rstart,
   input  logic [CNT_W-1:0] rend,
   input  logic [CNT_W-1:0] tstart,
   input  logic [CNT_W-1:0] tend,
   input  logic             sync,
   output logic             ien,
   output logic             oen,
   output logic             tx_rx,
   output logic             frame_start,
   output logic [31:0]      frame_num,
   output logic             adj_pending,
   output logic [CNT_W-1:0] cnt
);
   state_t           state;
   logic [CNT_W-1:0] len_q, rs_q, re_q, ts_q, te_q, adj_q, len_next;
   logic [CNT_W+1:0] sum;
   logic             rx_act, tx_act, sync_hit, boundary, load, stop, act;
`ifdef TDD_SYNC_EN
   assign sync_hit = sync;
`else
   logic unused_sync;
   assign unused_sync = sync;
   assign sync_hit    = 1'b0;
`endif
   // two guard bits keep the signed sum of length and correction exact before clamping
   always_comb begin
      sum      = {2'b00, frame_len} + (adj_pending ? {{2{adj_q[CNT_W-1]}}, adj_q} : '0);
      len_next = sum[CNT_W+1] ? CNT_W'(MIN_LEN) :
                 sum[CNT_W] ? '1 :
                 sum[CNT_W-1:0] < CNT_W'(MIN_LEN) ? CNT_W'(MIN_LEN) : sum[CNT_W-1:0];
   end
   // frame events: boundary closes a frame, load starts one, stop returns to idle
   always_comb begin
      act      = state == RUN && en;
      boundary = act && (cnt == len_q - 1'b1 || sync_hit);
      load     = (state == IDLE && en) || boundary;
      stop     = state == RUN && !en;
   end
   tdd_window_cmp #(.W(CNT_W)) u_rx (.s(rs_q), .e(re_q), .c(cnt), .len(len_q), .active(rx_act));
   tdd_window_cmp #(.W(CNT_W)) u_tx (.s(ts_q), .e(te_q), .c(cnt), .len(len_q), .active(tx_act));
   // frame FSM, shadow registers and registered enables (transmit wins on overlap)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         len_q       <= '0;
         rs_q        <= '0;
         re_q        <= '0;
         ts_q        <= '0;
         te_q        <= '0;
         adj_q       <= '0;
         adj_pending <= 1'b0;
         frame_num   <= '0;
         ien         <= 1'b0;
         oen         <= 1'b0;
         tx_rx       <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         ien         <= act && rx_act && !tx_act;
         oen         <= act && tx_act;
         tx_rx       <= act && tx_act;
         frame_start <= act && cnt == '0;
         state       <= en ? RUN : IDLE;
         cnt         <= act && !boundary ? cnt + 1'b1 : '0;
         adj_pending <= adj_req || (adj_pending && !load && !stop);
         if (adj_req) adj_q <= frame_adj;
         if (boundary) frame_num <= frame_num + 1'b1;
         if (load) begin
            len_q <= len_next;
            rs_q  <= rstart;
            re_q  <= rend;
            ts_q  <= tstart;
            te_q  <= tend;
         end
      end
   end
endmodule

// File: tb/tb_tdd_frame_sched.sv
// tb_tdd_frame_sched: randomized and directed checks of tdd_frame_sched against a behavioural model
module tb_tdd_frame_sched;
   localparam int W    = 8;
   localparam int MAXV = (1 << W) - 1;
`ifdef TDD_SYNC_EN
   localparam bit SYNC = 1'b1;
`else
   localparam bit SYNC = 1'b0;
`endif
   logic clk = 0, rst_n = 0, en = 0, adj_req = 0, sync = 0;
   logic [W-1:0] frame_len = 0, frame_adj = 0, rstart = 0, rend = 0, tstart = 0, tend = 0;
   logic ien, oen, tx_rx, frame_start, adj_pending;
   logic [31:0] frame_num;
   logic [W-1:0] cnt;
   wire [44:0] obs = {ien, oen, tx_rx, frame_start, adj_pending, cnt, frame_num};
   int passed = 0, total = 0;
   bit m_run, m_pend, e_ien, e_oen, e_fs;
   int m_pos, m_len, m_rs, m_re, m_ts, m_te, m_adj;
   bit [31:0] m_fnum;

   always #5 clk = ~clk;

   tdd_frame_sched #(.CNT_W(W)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .frame_len(frame_len), .frame_adj(frame_adj),
      .adj_req(adj_req), .rstart(rstart), .rend(rend), .tstart(tstart), .tend(tend),
      .sync(sync), .ien(ien), .oen(oen), .tx_rx(tx_rx), .frame_start(frame_start),
      .frame_num(frame_num), .adj_pending(adj_pending), .cnt(cnt)
   );

   function automatic bit in_win(int s, int e, int c);
      if (s < e) return c >= s && c < e;
      if (s > e) return c >= s || c < e;
      return 0;
   endfunction

   function automatic int eff_len(int len, int adj);
      int l = len + adj;
      if (l < 2) l = 2;
      if (l > MAXV) l = MAXV;
      return l;
   endfunction

   function automatic bit bnd_now();
      return m_run && en && (m_pos == m_len - 1 || (SYNC && sync));
   endfunction

   function automatic bit start_now();
      return (!m_run && en) || bnd_now();
   endfunction

   function automatic logic [44:0] exp_vec();
      return {e_ien, e_oen, e_oen, e_fs, m_pend, W'(m_pos), m_fnum};
   endfunction

   // reference model: frame position, per-frame length and window rules in plain integers
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run <= 0; m_pend <= 0; m_pos <= 0; m_len <= 0; m_adj <= 0; m_fnum <= 0;
         m_rs <= 0; m_re <= 0; m_ts <= 0; m_te <= 0;
         e_ien <= 0; e_oen <= 0; e_fs <= 0;
      end else begin
         e_oen  <= m_run && en && in_win(m_ts, m_te, m_pos);
         e_ien  <= m_run && en && in_win(m_rs, m_re, m_pos) && !in_win(m_ts, m_te, m_pos);
         e_fs   <= m_run && en && m_pos == 0;
         m_pend <= adj_req || (m_pend && !start_now() && !(m_run && !en));
         if (adj_req) m_adj <= int'($signed(frame_adj));
         if (start_now()) begin
            m_len <= eff_len(int'(frame_len), m_pend ? m_adj : 0);
            m_rs <= rstart; m_re <= rend; m_ts <= tstart; m_te <= tend;
         end
         if (bnd_now()) m_fnum <= m_fnum + 1;
         m_pos <= (m_run && en && !bnd_now()) ? m_pos + 1 : 0;
         m_run <= en;
      end
   end

   task automatic wait_fs(output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (!frame_start && n < 600);
      if (!frame_start) begin total++; $display("FAIL fs_timeout: no frame_start within %0d cycles", n); end
   endtask

   task automatic wait_cnt(input int v);
      int g = 0;
      do begin @(negedge clk); g++; end while (int'(cnt) != v && g < 600);
      if (int'(cnt) != v) begin total++; $display("FAIL cnt_timeout: cnt never reached %0d", v); end
   endtask

   task automatic test_reset;
      rst_n = 0;
      repeat (3) @(negedge clk);
      total++; if (obs !== 45'd0) $display("FAIL reset_values: got %h want 0", obs); else passed++;
      rst_n = 1;
      @(negedge clk);
      total++; if (obs !== 45'd0) $display("FAIL idle_after_reset: got %h want 0", obs); else passed++;
   endtask

   task automatic test_basic;
      int n, ni = 0, no = 0, nf = 0;
      frame_len = 10; rstart = 0; rend = 4; tstart = 5; tend = 8; en = 1;
      wait_fs(n);
      total++; if (n !== 2) $display("FAIL first_fs_latency: got %0d want 2", n); else passed++;
      for (int k = 0; k < 20; k++) begin
         if (k != 0) @(negedge clk);
         total++; if (obs !== exp_vec()) $display("FAIL basic_model k=%0d: got %h want %h", k, obs, exp_vec()); else passed++;
         ni += int'(ien); no += int'(oen); nf += int'(frame_start);
      end
      total++;
      if (ni !== 8 || no !== 6 || nf !== 2 || frame_num !== 32'd2)
         $display("FAIL basic_counts: got ien=%0d oen=%0d fs=%0d fn=%0d want 8 6 2 2", ni, no, nf, frame_num);
      else passed++;
   endtask

   task automatic test_adjust;
      int n, n1, n2;
      wait_cnt(4);
      frame_adj = W'(-3); adj_req = 1;
      @(negedge clk); adj_req = 0;
      total++; if (adj_pending !== 1'b1) $display("FAIL adj_pending_set: got %b want 1", adj_pending); else passed++;
      wait_fs(n); wait_fs(n1); wait_fs(n2);
      total++; if (n1 !== 7 || n2 !== 10) $display("FAIL adj_lengths: got %0d,%0d want 7,10", n1, n2); else passed++;
      total++; if (adj_pending !== 1'b0) $display("FAIL adj_pending_clear: got %b want 0", adj_pending); else passed++;
      wait_cnt(9);
      adj_req = 1;
      @(negedge clk); adj_req = 0;
      total++; if (adj_pending !== 1'b1) $display("FAIL adj_boundary_pending: got %b want 1", adj_pending); else passed++;
      wait_fs(n); wait_fs(n1); wait_fs(n2);
      total++; if (n1 !== 10 || n2 !== 7) $display("FAIL adj_boundary_lengths: got %0d,%0d want 10,7", n1, n2); else passed++;
   endtask

   task automatic test_wrap_clamp;
      int n, n1, n2;
      logic [9:0] imask = '0, omask = '0;
      rstart = 8; rend = 2; tstart = 3; tend = 3;
      wait_fs(n);
      for (int k = 0; k < 10; k++) begin
         if (k != 0) @(negedge clk);
         total++; if (obs !== exp_vec()) $display("FAIL wrap_model k=%0d: got %h want %h", k, obs, exp_vec()); else passed++;
         imask[k] = ien; omask[k] = oen;
      end
      total++; if (imask !== 10'h303 || omask !== 10'h000) $display("FAIL wrap_mask: got ien=%h oen=%h want 303 000", imask, omask); else passed++;
      wait_cnt(4);
      frame_len = 1; frame_adj = W'(-5); adj_req = 1;
      @(negedge clk); adj_req = 0;
      wait_fs(n); wait_fs(n1); wait_fs(n2);
      total++; if (n1 !== 2 || n2 !== 2) $display("FAIL clamp_lengths: got %0d,%0d want 2,2", n1, n2); else passed++;
   endtask

   task automatic test_saturate;
      int n, n1, n2;
      wait_fs(n);
      @(negedge clk);
      frame_len = 250; frame_adj = W'(100); adj_req = 1;
      @(negedge clk); adj_req = 0;
      wait_fs(n); wait_fs(n1); wait_fs(n2);
      total++; if (n1 !== 255 || n2 !== 250) $display("FAIL saturate_lengths: got %0d,%0d want 255,250", n1, n2); else passed++;
   endtask

   task automatic test_overlap;
      int n;
      logic [9:0] imask = '0, omask = '0, tmask = '0;
      frame_len = 10; rstart = 0; rend = 6; tstart = 4; tend = 8;
      wait_fs(n); wait_fs(n);
      for (int k = 0; k < 10; k++) begin
         if (k != 0) @(negedge clk);
         total++; if (obs !== exp_vec()) $display("FAIL overlap_model k=%0d: got %h want %h", k, obs, exp_vec()); else passed++;
         imask[k] = ien; omask[k] = oen; tmask[k] = tx_rx;
      end
      total++;
      if (imask !== 10'h00f || omask !== 10'h0f0 || tmask !== 10'h0f0)
         $display("FAIL overlap_mask: got ien=%h oen=%h txrx=%h want 00f 0f0 0f0", imask, omask, tmask);
      else passed++;
   endtask

   task automatic test_sync;
      int n;
      logic [31:0] fn;
      wait_cnt(6);
      fn = frame_num; sync = 1;
      @(negedge clk); sync = 0;
      total++;
      if (cnt !== (SYNC ? 8'd0 : 8'd7) || frame_num !== fn + 32'(SYNC))
         $display("FAIL sync_mid: got cnt=%0d fn=%0d want cnt=%0d fn=%0d", cnt, frame_num, SYNC ? 0 : 7, fn + 32'(SYNC));
      else passed++;
      wait_fs(n); wait_fs(n);
      total++; if (n !== 10) $display("FAIL sync_next_len: got %0d want 10", n); else passed++;
      wait_cnt(9);
      fn = frame_num; sync = 1;
      @(negedge clk); sync = 0;
      total++;
      if (cnt !== 8'd0 || frame_num !== fn + 1)
         $display("FAIL sync_coincident: got cnt=%0d fn=%0d want 0 %0d", cnt, frame_num, fn + 1);
      else passed++;
   endtask

   task automatic test_en_drop;
      logic [31:0] fn;
      wait_cnt(3);
      frame_adj = W'(2); adj_req = 1;
      @(negedge clk); adj_req = 0;
      wait_cnt(5);
      fn = frame_num; en = 0;
      @(negedge clk);
      total++; if (obs !== {13'd0, fn}) $display("FAIL en_drop: got %h want %h", obs, {13'd0, fn}); else passed++;
      sync = 1;
      @(negedge clk); sync = 0;
      @(negedge clk);
      total++; if (obs !== {13'd0, fn}) $display("FAIL idle_sync: got %h want %h", obs, {13'd0, fn}); else passed++;
      en = 1;
      @(negedge clk);
      total++; if ({frame_start, cnt} !== 9'd0) $display("FAIL restart_first: got fs=%b cnt=%0d want 0 0", frame_start, cnt); else passed++;
      @(negedge clk);
      total++;
      if ({frame_start, cnt} !== {1'b1, 8'd1} || frame_num !== fn)
         $display("FAIL restart_fs: got fs=%b cnt=%0d fn=%0d want 1 1 %0d", frame_start, cnt, frame_num, fn);
      else passed++;
   endtask

   task automatic test_async_reset;
      wait_cnt(5);
      #2 rst_n = 0;
      #1;
      total++; if (obs !== 45'd0) $display("FAIL async_reset: got %h want 0", obs); else passed++;
      @(negedge clk); rst_n = 1;
      @(negedge clk);
      @(negedge clk);
      total++;
      if ({frame_start, cnt, frame_num} !== {1'b1, 8'd1, 32'd0})
         $display("FAIL reset_restart: got fs=%b cnt=%0d fn=%0d want 1 1 0", frame_start, cnt, frame_num);
      else passed++;
   endtask

   task automatic test_random;
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         total++; if (obs !== exp_vec()) $display("FAIL random k=%0d: got %h want %h", k, obs, exp_vec()); else passed++;
         adj_req   = $urandom_range(0, 19) == 0;
         sync      = $urandom_range(0, 29) == 0;
         en        = en ? $urandom_range(0, 59) != 0 : $urandom_range(0, 3) == 0;
         frame_adj = W'(int'($urandom_range(0, 16)) - 8);
         if ($urandom_range(0, 9) == 0) begin
            frame_len = W'($urandom_range(0, 24));
            rstart = W'($urandom_range(0, 26)); rend = W'($urandom_range(0, 26));
            tstart = W'($urandom_range(0, 26)); tend = W'($urandom_range(0, 26));
         end
      end
      adj_req = 0; sync = 0;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_adjust;
      test_wrap_clamp;
      test_saturate;
      test_overlap;
      test_sync;
      test_en_drop;
      test_async_reset;
      test_random;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
